// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
// Holds the FSM state encoding and the default count width.
package countdown_pkg;

  typedef enum logic [1:0] {
    CD_IDLE    = 2'd0,
    CD_RUN     = 2'd1,
    CD_EXPIRED = 2'd2
  } cd_state_t;

  localparam int CD_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle done pulse on expiry and optional auto-reload.
// All outputs are registered; the only asynchronous path is the active-low reset.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             busy,
  output logic             expired
);

  localparam logic [WIDTH-1:0] W_ZERO = '0;
  localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  cd_state_t        r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;
  logic             r_busy;
  logic             r_expired;

  cd_state_t        w_state_next;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_reload_next;
  logic             w_done_next;
  logic             w_expired_next;

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_reload_next  = r_reload;
    w_done_next    = 1'b0;
    w_expired_next = r_expired;

    if (load) begin
      // Load beats a simultaneous terminal decrement, so no done pulse here.
      w_reload_next  = load_value;
      w_count_next   = load_value;
      w_expired_next = 1'b0;
      w_state_next   = (load_value != W_ZERO) ? CD_RUN : CD_IDLE;
    end else begin
      case (r_state)
        CD_RUN: begin
          if (enable) begin
            if (r_count > W_ONE) begin
              w_count_next = r_count - W_ONE;
            end else if (r_count == W_ONE) begin
              w_done_next = 1'b1;
              if (auto_reload) begin
                w_count_next = r_reload;
              end else begin
                w_count_next   = W_ZERO;
                w_expired_next = 1'b1;
                w_state_next   = CD_EXPIRED;
              end
            end else begin
              // Unreachable zero count while running: park safely.
              w_state_next = CD_IDLE;
            end
          end
        end
        CD_EXPIRED: begin
          w_count_next = W_ZERO;
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= CD_IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_reload  <= w_reload_next;
      r_done    <= w_done_next;
      r_busy    <= (w_state_next == CD_RUN);
      r_expired <= w_expired_next;
    end
  end

  assign count   = r_count;
  assign done    = r_done;
  assign busy    = r_busy;
  assign expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: reset, one-shot, periodic, enable gaps,
// load collisions, boundary load values and asynchronous reset mid-count.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] load_value;
  logic       auto_reload;
  logic [3:0] count;
  logic       done;
  logic       busy;
  logic       expired;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .count      (count),
    .done       (done),
    .busy       (busy),
    .expired    (expired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int c, input int d, input int b, input int e);
    check({tag, ".count"},   32'(count),   32'(c));
    check({tag, ".done"},    32'(done),    32'(d));
    check({tag, ".busy"},    32'(busy),    32'(b));
    check({tag, ".expired"}, 32'(expired), 32'(e));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; load = 1'b0; load_value = 4'd0; auto_reload = 1'b0;

    // Reset held for 2 cycles, then idle with enable toggling.
    tick(); tick();
    outs("reset", 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enable = ~enable;
      tick();
      outs("idle", 0, 0, 0, 0);
    end

    // One-shot of 5.
    load = 1'b1; load_value = 4'd5; auto_reload = 1'b0; enable = 1'b1;
    tick();
    outs("os_load", 5, 0, 1, 0);
    load = 1'b0;
    for (int v = 4; v >= 1; v--) begin
      tick();
      outs("os_dec", v, 0, 1, 0);
    end
    tick();
    outs("os_term", 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      outs("os_hold", 0, 0, 0, 1);
    end

    // Periodic of 3; load also clears the sticky expired flag.
    load = 1'b1; load_value = 4'd3; auto_reload = 1'b1;
    tick();
    outs("per_load", 3, 0, 1, 0);
    load = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      outs("per", 3 - (i % 3), (i % 3 == 0) ? 1 : 0, 1, 0);
    end

    // Enable on alternate cycles: 4 decrements need 8 cycles.
    load = 1'b1; load_value = 4'd4; auto_reload = 1'b0; enable = 1'b0;
    tick();
    outs("gap_load", 4, 0, 1, 0);
    load = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      enable = (j % 2 == 0);
      tick();
      if (j < 8) outs("gap", 4 - j / 2, 0, 1, 0);
      else       outs("gap_term", 0, 1, 0, 1);
    end

    // Load collides with terminal decrement: load wins.
    load = 1'b1; load_value = 4'd2; enable = 1'b1;
    tick();
    outs("col_load2", 2, 0, 1, 0);
    load = 1'b0;
    tick();
    outs("col_at1", 1, 0, 1, 0);
    load = 1'b1; load_value = 4'd7;
    tick();
    outs("col_load7", 7, 0, 1, 0);

    // Load of zero from RUN: straight to IDLE, no pulse, enable ignored.
    load_value = 4'd0;
    tick();
    outs("load0", 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      outs("load0_idle", 0, 0, 0, 0);
    end

    // Load of 1 expires one enabled cycle later.
    load = 1'b1; load_value = 4'd1;
    tick();
    outs("one_load", 1, 0, 1, 0);
    load = 1'b0;
    tick();
    outs("one_term", 0, 1, 0, 1);

    // Max value, then asynchronous reset between edges.
    load = 1'b1; load_value = 4'd15;
    tick();
    outs("max_load", 15, 0, 1, 0);
    load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    outs("max_run6", 9, 0, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    outs("async_rst", 0, 0, 0, 0);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      outs("post_rst", 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter timer: the count-down complement of the free-running up-counter. It is loaded with a start value, decrements on each enabled clock, and signals expiry with a one-cycle `done` pulse. Optional auto-reload makes it a periodic tick generator. It sits beside the up-counter in the counter library and serves as a programmable delay or timeout source for control logic.

## Interface
- `WIDTH`, 4: bit width of the count and of the load value.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  asynchronous, active-low reset.
- `enable`  input  1  decrement qualifier; sampled every cycle in RUN.
- `load`  input  1  synchronous load strobe; highest priority after reset.
- `load_value`  input  WIDTH  start value, captured when `load`=1.
- `auto_reload`  input  1  on expiry, 1 reloads the captured value; 0 stops.
- `count`  output  WIDTH  current count value (registered).
- `done`  output  1  one-cycle pulse on each expiry (registered).
- `busy`  output  1  high while state is RUN.
- `expired`  output  1  sticky; set on non-reload expiry, cleared by `load`.

## Operation
- Internal state: FSM {IDLE, RUN, EXPIRED} plus `reload_reg[WIDTH-1:0]`.
- Reset (`reset`=0, async): state=IDLE, `count`=0, `reload_reg`=0, `done`=0, `busy`=0, `expired`=0.
- `load`=1, any state: `reload_reg`←`load_value`, `count`←`load_value`, `expired`←0, `done`←0.
  - `load_value`≠0 → RUN.
  - `load_value`=0 → IDLE, with no `done` pulse.
- IDLE: all outputs hold. `enable` is ignored.
- RUN, `enable`=0: `count` holds.
- RUN, `enable`=1, `count`>1: `count`←`count`−1.
- RUN, `enable`=1, `count`=1 (terminal):
  - `done`←1 for exactly one cycle.
  - If `auto_reload`=1: `count`←`reload_reg`, stay in RUN.
  - If `auto_reload`=0: `count`←0, `expired`←1, go to EXPIRED.
- EXPIRED: `count`=0 and holds. `enable` is ignored. Leaves only on `load`.
- `done` is 0 in every cycle not following a terminal decrement.
- `auto_reload` is sampled only in the terminal cycle.
- Arithmetic is unsigned and modulo-free. `count` never wraps below 0, because decrement happens only when `count`≥1.
- `busy` = (state==RUN), registered together with the state.

## Timing
- Load at edge k → `count`=`load_value` visible after edge k. The first decrement occurs at edge k+1 if `enable`=1.
- With `enable` held high and value N loaded, `done` is high for the cycle after edge k+N, with `count` reading 0 (or N on reload).
- Auto-reload period with continuous `enable` is exactly N cycles between `done` pulses.
- Gaps in `enable` stretch the period one-for-one.
- Simultaneous `load` and terminal decrement: `load` wins. No `done`, `count`=`load_value`.
- `load` while in RUN restarts the timer immediately. The pending count is discarded.
- Reset asserted mid-count: all outputs go to their reset values asynchronously. After release the block stays in IDLE until the next `load`.
- `load_value`=1: `done` fires one enabled cycle after the load.
- `load_value`=2^WIDTH−1 is fully supported; no overflow path exists.

## Structure
- Package `countdown_pkg` holds:
  - the state typedef `cd_state_t` {CD_IDLE, CD_RUN, CD_EXPIRED};
  - the default width constant `CD_WIDTH_DEFAULT`=4.
- Single module, no sub-module. The FSM, count register and reload register live in one sequential process, with next-state/next-count logic in one combinational process.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, release, toggle `enable` for 10 cycles → `count`=0, `busy`=0, `done`=0, `expired`=0 throughout.
- One-shot: load 5, `auto_reload`=0, `enable`=1 → `count` reads 5,4,3,2,1,0. `done` is high for one cycle when `count` reaches 0. `expired`=1 and `busy`=0 afterward. `count` stays 0 for 10 more cycles.
- Periodic: load 3, `auto_reload`=1, `enable`=1 for 20 cycles → `done` pulses every 3 cycles. `count` sequence is 3,2,1,3,2,1… and `busy` stays 1.
- Enable gaps and pause: load 4, pulse `enable` on alternate cycles → `done` arrives after 8 cycles. `count` holds during `enable`=0.
- Collisions: load 2 and run to `count`=1, then assert `load` with value 7 together with `enable` → no `done`, `count`=7. Separately, load 0 → state IDLE, no `done`.
- Async reset mid-run: load 15, run 6 cycles (`count`=9), pull `reset` low between clock edges → `count`=0, `busy`=0 immediately, without waiting for a clock edge.
